anotherworld_thread_scheduler: RTL

ANOTHERWORLD_THREAD_SCHEDULER -- requirements
Module: anotherworld_thread_scheduler

---
 rtl/anotherworld_pkg.sv | 15 +
 rtl/anotherworld_thread_table.sv | 54 +++++
 rtl/anotherworld_thread_scheduler.sv | 101 ++++++++++
 3 files changed

// File: rtl/anotherworld_pkg.sv
// anotherworld_pkg: shared thread count, special PC values and scheduler state encoding.
package anotherworld_pkg;
    localparam int NUM_THREADS = 64;
    localparam int THREAD_W = 6;
    localparam logic [15:0] PC_INACTIVE = 16'hFFFF;
    localparam logic [15:0] PC_KILL = 16'hFFFE;
    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SCAN,
        S_DISPATCH,
        S_RUN,
        S_DONE
    } sched_state_t;
endpackage

// File: rtl/anotherworld_thread_table.sv
// anotherworld_thread_table: per-thread pc/paused state plus pending setVec/freeze requests.
module anotherworld_thread_table #(
    parameter int NUM_THREADS = anotherworld_pkg::NUM_THREADS,
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      idx,
    input  logic            apply_en,
    input  logic            run_wr_en,
    input  logic [PC_W-1:0] run_wr_pc,
    output logic [PC_W-1:0] rd_pc,
    output logic            rd_paused,
    input  logic            setvec_valid,
    input  logic [5:0]      setvec_thread,
    input  logic [PC_W-1:0] setvec_pc,
    input  logic            freeze_valid,
    input  logic [5:0]      freeze_thread,
    input  logic            freeze_val
);
    import anotherworld_pkg::*;
    localparam logic [PC_W-1:0] INACT = PC_W'(PC_INACTIVE);
    localparam logic [PC_W-1:0] KILL = PC_W'(PC_KILL);
    logic [PC_W-1:0] pc [NUM_THREADS];
    logic [PC_W-1:0] req_pc [NUM_THREADS];
    logic [NUM_THREADS-1:0] paused, req_paused;
    assign rd_pc = pc[idx];
    assign rd_paused = paused[idx];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc[i] <= (i == 0) ? '0 : INACT;
                req_pc[i] <= INACT;
            end
            paused <= '0;
            req_paused <= '0;
        end else begin
            if (apply_en) begin
                if (req_pc[idx] != INACT) begin
                    pc[idx] <= (req_pc[idx] == KILL) ? INACT : req_pc[idx];
                    req_pc[idx] <= INACT;
                end
                paused[idx] <= req_paused[idx];
            end
            if (run_wr_en)
                pc[idx] <= run_wr_pc;
            // placed after the apply clear so a same-cycle request survives
            if (setvec_valid)
                req_pc[setvec_thread] <= setvec_pc;
            if (freeze_valid)
                req_paused[freeze_thread] <= freeze_val;
        end
    end
endmodule

// File: rtl/anotherworld_thread_scheduler.sv
// anotherworld_thread_scheduler: per-frame round of VM threads -- apply requests, then dispatch each runnable thread once in index order.
module anotherworld_thread_scheduler #(
    parameter int NUM_THREADS = anotherworld_pkg::NUM_THREADS,
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            frame_start,
    input  logic            setvec_valid,
    input  logic [5:0]      setvec_thread,
    input  logic [PC_W-1:0] setvec_pc,
    input  logic            freeze_valid,
    input  logic [5:0]      freeze_thread,
    input  logic            freeze_val,
    output logic            cpu_start,
    output logic [PC_W-1:0] cpu_pc,
    output logic [5:0]      cpu_thread,
    input  logic            cpu_yield,
    input  logic            cpu_kill,
    input  logic [PC_W-1:0] cpu_resume_pc,
    output logic            busy,
    output logic            frame_done,
    output logic            overrun
);
    import anotherworld_pkg::*;
    localparam logic [PC_W-1:0] INACT = PC_W'(PC_INACTIVE);
    sched_state_t state;
    logic [5:0] idx;
    logic [PC_W-1:0] rd_pc;
    logic rd_paused, last, runnable, run_end;
    assign last = idx == 6'(NUM_THREADS - 1);
    assign runnable = rd_pc != INACT && !rd_paused;
    assign run_end = state == S_RUN && (cpu_yield || cpu_kill);

    anotherworld_thread_table #(.NUM_THREADS(NUM_THREADS), .PC_W(PC_W)) u_table (
        .clk          (clk),
        .reset        (reset),
        .idx          (idx),
        .apply_en     (state == S_APPLY),
        .run_wr_en    (run_end),
        .run_wr_pc    (cpu_kill ? INACT : cpu_resume_pc),
        .rd_pc        (rd_pc),
        .rd_paused    (rd_paused),
        .setvec_valid (setvec_valid),
        .setvec_thread(setvec_thread),
        .setvec_pc    (setvec_pc),
        .freeze_valid (freeze_valid),
        .freeze_thread(freeze_thread),
        .freeze_val   (freeze_val)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            idx <= '0;
            cpu_start <= 1'b0;
            frame_done <= 1'b0;
            busy <= 1'b0;
            overrun <= 1'b0;
            cpu_pc <= '0;
            cpu_thread <= '0;
        end else begin
            cpu_start <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start && busy)
                overrun <= 1'b1;
            case (state)
                S_IDLE: if (frame_start) begin
                    state <= S_APPLY;
                    idx <= '0;
                    busy <= 1'b1;
                end
                S_APPLY: begin
                    state <= last ? S_SCAN : S_APPLY;
                    idx <= last ? '0 : idx + 6'd1;
                end
                S_SCAN: if (runnable) begin
                    state <= S_DISPATCH;
                    cpu_start <= 1'b1;
                    cpu_pc <= rd_pc;
                    cpu_thread <= idx;
                end else if (last) begin
                    state <= S_DONE;
                    frame_done <= 1'b1;
                end else
                    idx <= idx + 6'd1;
                S_DISPATCH: state <= S_RUN;
                S_RUN: if (run_end) begin
                    state <= last ? S_DONE : S_SCAN;
                    frame_done <= last;
                    idx <= last ? idx : idx + 6'd1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
